descrambler2: RTL and testbench



---
 rtl/descrambler2.sv | 140 ++++++++++++++
 tb/tb_descrambler2.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/descrambler2.sv
// descrambler2: buffered self-synchronising descrambler, polynomial x^7 + x^4 + 1.
// The user fills a 32-byte input window. Start descrambles bytes 0..len_1, one byte
// per clock, into a 32-byte output window. That window is read back through a
// registered port.
// Optional feature: define DESCR_BYPASS_EN to add a 'bypass' input. When bypass is
// latched high at start, the operation copies bytes unchanged with the same timing.

// One bit lane of the descrambler. The received (scrambled) bit feeds the shift register.
module descr2_bit (
  input  logic       b,
  input  logic [6:0] s_in,
  output logic       o,
  output logic [6:0] s_out
);
  assign o     = b ^ s_in[6] ^ s_in[3];
  assign s_out = {s_in[5:0], b};
endmodule

module descrambler2 #(
  parameter logic [15:0] IN_BASE  = 16'hF050,
  parameter logic [15:0] OUT_BASE = 16'hF070,
  parameter logic [6:0]  SEED     = 7'h7F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  len_1,
`ifdef DESCR_BYPASS_EN
  input  logic        bypass,
`endif
  input  logic [15:0] usr_w_addr,
  input  logic [7:0]  usr_din,
  input  logic        usr_wr_en,
  input  logic [15:0] usr_r_addr,
  output logic        busy,
  output logic        done,
  output logic [7:0]  dout
);
  localparam int NBITS = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;
  logic [4:0] idx, len_q;
  logic [6:0] s, s_nx;
  logic [7:0] in_mem  [32];
  logic [7:0] out_mem [32];
  logic [7:0] cur, descr, res;
  logic [NBITS:0][6:0] s_chain;
  logic [15:0] w_off, r_off;
  logic w_hit, r_hit;

  // The offset subtraction wraps for addresses below the base, so one compare covers the whole window.
  assign w_off = usr_w_addr - IN_BASE;
  assign r_off = usr_r_addr - OUT_BASE;
  assign w_hit = usr_wr_en && (state == IDLE) && (w_off < 16'd32);
  assign r_hit = r_off < 16'd32;
  assign cur   = in_mem[idx];

  // Eight chained bit lanes, LSB first, form the whole byte step in one cycle.
  assign s_chain[0] = s;
  for (genvar i = 0; i < NBITS; i++) begin : g_bit
    descr2_bit u_bit (
      .b     (cur[i]),
      .s_in  (s_chain[i]),
      .o     (descr[i]),
      .s_out (s_chain[i+1])
    );
  end

`ifdef DESCR_BYPASS_EN
  logic byp_q;
  assign res  = byp_q ? cur : descr;
  assign s_nx = byp_q ? s : s_chain[NBITS];
`else
  assign res  = descr;
  assign s_nx = s_chain[NBITS];
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic. A start request is only seen in IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (idx == len_q) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control and datapath registers. busy and done are registered copies of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      len_q <= '0;
      s     <= SEED;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef DESCR_BYPASS_EN
      byp_q <= 1'b0;
`endif
    end else begin
      busy <= (state_nx != IDLE);
      done <= (state_nx == DONE);
      case (state)
        IDLE: if (start) begin
          idx   <= '0;
          len_q <= len_1;
          s     <= SEED;
`ifdef DESCR_BYPASS_EN
          byp_q <= bypass;
`endif
        end
        RUN: begin
          s <= s_nx;
          if (idx != len_q) idx <= idx + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Buffers are not reset. An asynchronous reset forces IDLE, so result writes stop at once.
  always_ff @(posedge clk) begin
    if (w_hit)         in_mem[w_off[4:0]] <= usr_din;
    if (state == RUN)  out_mem[idx]       <= res;
  end

  // Registered read port. It is live at all times, including during an operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout <= 8'h00;
    else     dout <= r_hit ? out_mem[r_off[4:0]] : 8'h00;
  end
endmodule

// File: tb/tb_descrambler2.sv
// Scoreboard bench for descrambler2: stimulus pushes expectations, a monitor pops them.
module tb_descrambler2;
  localparam logic [15:0] IN_BASE  = 16'hF050;
  localparam logic [15:0] OUT_BASE = 16'hF070;
  localparam logic [6:0]  SEED     = 7'h7F;

  logic clk, rst, start, usr_wr_en, busy, done;
  logic [4:0]  len_1;
  logic [15:0] usr_w_addr, usr_r_addr;
  logic [7:0]  usr_din, dout;
`ifdef DESCR_BYPASS_EN
  logic bypass;
`endif

  descrambler2 dut (
    .clk(clk), .rst(rst), .start(start), .len_1(len_1),
`ifdef DESCR_BYPASS_EN
    .bypass(bypass),
`endif
    .usr_w_addr(usr_w_addr), .usr_din(usr_din), .usr_wr_en(usr_wr_en),
    .usr_r_addr(usr_r_addr), .busy(busy), .done(done), .dout(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic [15:0] a; logic [7:0] v;} rd_t;
  rd_t exp_rd[$];
  int  exp_busy[$];
  int  exp_done[$];

  int n_tests = 0, n_fail = 0;
  logic [7:0] in_model  [32];
  logic [7:0] out_model [32];
  bit         out_known [32];
  logic rd_issue = 1'b0, rd_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference: treat the received stream as one bit sequence c[] with the seed
  // standing in for the 7 bits before it. out[k] = c[k] ^ c[k-7] ^ c[k-4].
  function automatic void model_run(input int len, input bit byp);
    bit st[$];
    for (int i = 0; i < 7; i++) st.push_back(SEED[6-i]);
    for (int n = 0; n <= len; n++)
      for (int b = 0; b < 8; b++) st.push_back(in_model[n][b]);
    for (int n = 0; n <= len; n++) begin
      logic [7:0] o;
      for (int b = 0; b < 8; b++) begin
        int k;
        k = n * 8 + b;
        o[b] = st[k+7] ^ st[k] ^ st[k+3];
      end
      out_model[n] = byp ? in_model[n] : o;
      out_known[n] = 1'b1;
    end
  endfunction

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    logic [15:0] off;
    off = a - IN_BASE;
    usr_w_addr = a; usr_din = d; usr_wr_en = 1'b1;
    if (off < 16'd32) in_model[off[4:0]] = d;
    tick();
    usr_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] v);
    rd_t r;
    r.a = a; r.v = v;
    exp_rd.push_back(r);
    usr_r_addr = a; rd_issue = 1'b1;
    tick();
    rd_issue = 1'b0;
  endtask

  task automatic rd_all();
    for (int i = 0; i < 32; i++)
      if (out_known[i]) rd(OUT_BASE + 16'(i), out_model[i]);
    rd(OUT_BASE - 16'd1, 8'h00);
    rd(OUT_BASE + 16'd32, 8'h00);
  endtask

  // Run one operation. ms/mw: busy cycle at which to pulse start / attempt a write (-1 = none).
  task automatic run(input int len, input int ms, input int mw);
    int n;
    bit b;
    b = 1'b0;
`ifdef DESCR_BYPASS_EN
    b = ($urandom_range(0, 3) == 0);
    bypass = b;
`endif
    len_1 = 5'(len); start = 1'b1;
    model_run(len, b);
    exp_busy.push_back(len + 2);
    exp_done.push_back(1);
    tick();
    start = 1'b0;
    len_1 = 5'($urandom);
`ifdef DESCR_BYPASS_EN
    bypass = ~b;
`endif
    n = 0;
    while (busy && n < 64) begin
      start = (n == ms);
      if (n == mw) begin
        usr_w_addr = IN_BASE; usr_din = ~in_model[0]; usr_wr_en = 1'b1;
      end else usr_wr_en = 1'b0;
      tick();
      n++;
    end
    start = 1'b0; usr_wr_en = 1'b0;
    chk("run_timeout", n >= 64, 1'b0);
  endtask

  // Capture stage for reads: the monitor expects dout one edge after the address.
  initial forever begin
    @(posedge clk);
    rd_pend = rd_issue;
  end

  // Monitor: compares read data and measures each busy window against the scoreboard.
  initial begin
    int bc, dc, da, eb, ed;
    logic pb;
    rd_t r;
    bc = 0; dc = 0; da = 0; pb = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        if (exp_rd.size() == 0) chk("rd_underflow", 1'b1, 1'b0);
        else begin
          r = exp_rd.pop_front();
          chk($sformatf("dout@%h", r.a), dout, r.v);
        end
      end
      if (busy) begin
        bc++;
        if (done) begin dc++; da = bc; end
      end else if (done) chk("done_while_idle", done, 1'b0);
      if (pb && !busy) begin
        if (exp_busy.size() == 0) chk("busy_underflow", 1'b1, 1'b0);
        else begin
          eb = exp_busy.pop_front();
          ed = exp_done.pop_front();
          chk("busy_len", bc, eb);
          chk("done_cnt", dc, ed);
          if (ed == 1) chk("done_pos", da, bc);
        end
        bc = 0; dc = 0; da = 0;
      end
      pb = busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int len;
    bit b;
    rst = 1'b1; start = 1'b0; len_1 = '0; usr_wr_en = 1'b0;
    usr_w_addr = '0; usr_din = '0; usr_r_addr = '0;
`ifdef DESCR_BYPASS_EN
    bypass = 1'b0;
`endif
    #3;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_dout", dout, 8'h00);
    tick(); tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 32; i++) wr(IN_BASE + 16'(i), 8'($urandom));

    // Single zero byte and two zero bytes, with known results
    wr(IN_BASE, 8'h00);
    run(0, -1, -1);
    rd(OUT_BASE, 8'h70);
    wr(IN_BASE + 16'd1, 8'h00);
    run(1, -1, -1);
    rd(OUT_BASE, 8'h70);
    rd(OUT_BASE + 16'd1, 8'h00);

    // Ten bytes 01..0A, then again with a start pulse mid-run
    for (int i = 0; i < 10; i++) wr(IN_BASE + 16'(i), 8'(i + 1));
    run(9, -1, -1);
    rd_all();
    run(9, 3, -1);
    rd_all();

    // Guards: out-of-window writes, writes while busy (RUN and DONE), reads outside the window
    wr(IN_BASE - 16'd1, 8'hAA);
    wr(OUT_BASE, 8'hBB);
    wr(IN_BASE + 16'd32, 8'hCC);
    run(5, -1, 2);
    run(5, -1, 6);
    run(0, -1, -1);
    rd_all();
    rd(16'hF06F, 8'h00);

    // Write and start in the same cycle: the run sees the new byte
    d = 8'($urandom);
    usr_w_addr = IN_BASE; usr_din = d; usr_wr_en = 1'b1;
    in_model[0] = d;
    run(0, -1, -1);
    rd(OUT_BASE, out_model[0]);

    // Randomized operations
    for (int it = 0; it < 8; it++) begin
      int nw;
      nw = $urandom_range(0, 12);
      for (int w = 0; w < nw; w++) wr(IN_BASE - 16'd2 + 16'($urandom_range(0, 35)), 8'($urandom));
      len = $urandom_range(0, 31);
      run(len, ($urandom_range(0, 1) == 1) ? $urandom_range(0, len + 1) : -1, -1);
      rd_all();
    end

    // Reset while RUN is on byte 3: bytes 0..2 are written, the rest keep their old values
    for (int i = 0; i < 10; i++) wr(IN_BASE + 16'(i), 8'($urandom));
    usr_r_addr = OUT_BASE;
    tick();
    b = 1'b0;
`ifdef DESCR_BYPASS_EN
    b = ($urandom_range(0, 3) == 0);
    bypass = b;
`endif
    exp_busy.push_back(3);
    exp_done.push_back(0);
    len_1 = 5'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_dout", dout, 8'h00);
    model_run(2, b);
    tick(); tick();
    rst = 1'b0;
    tick();
    rd_all();
    run(31, -1, -1);
    rd_all();

    repeat (4) tick();
    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("busy_queue_empty", exp_busy.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
